// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the two-master memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_pkg;

  localparam int AW          = 9;
  localparam int DW          = 16;
  localparam int RAM_SEL_BIT = AW - 1;

  // Master command encoding; 2'b11 is treated as no request
  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  // Arbiter FSM encoding
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] ACCESS = 2'b01;
  localparam logic [1:0] DONE   = 2'b10;

  // Transaction captured at grant time and held until its ack
  typedef struct packed {
    logic          id;
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  function automatic logic cmd_vld(input logic [1:0] cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Master-side request/ack bundle plus the RAM (and optional IO) port.
// Latency: n/a (wiring only).
// Backpressure: masters hold cmd/addr/wdata until their ack pulse.
interface mem_arbiter_if;
  import mem_pkg::*;

  logic [1:0]    m0_cmd;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;

  logic [1:0]    m1_cmd;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;

  logic [AW-2:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_write;
  logic [DW-1:0] ram_dout;

`ifdef MEM_ARBITER_IO_EN
  logic [AW-2:0] io_addr;
  logic          io_write;
  logic [DW-1:0] io_wdata;
  logic [DW-1:0] io_rdata;
`endif

  // Environment side: masters plus the RAM/IO models
  modport master (
`ifdef MEM_ARBITER_IO_EN
    output io_rdata,
    input  io_addr, io_write, io_wdata,
`endif
    output m0_cmd, m0_addr, m0_wdata, m1_cmd, m1_addr, m1_wdata, ram_dout,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata, ram_addr, ram_din, ram_write
  );

  // Arbiter side
  modport slave (
`ifdef MEM_ARBITER_IO_EN
    input  io_rdata,
    output io_addr, io_write, io_wdata,
`endif
    input  m0_cmd, m0_addr, m0_wdata, m1_cmd, m1_addr, m1_wdata, ram_dout,
    output m0_ack, m0_rdata, m1_ack, m1_rdata, ram_addr, ram_din, ram_write
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker; the pointer register lives in the parent.
// Latency: combinational.
// Backpressure: none; grant_vld is simply the OR of the requests.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic       gnt_id_o,
  output logic       gnt_vld_o
);

  // Lone requester wins outright; on contention the pointer decides
  always_comb begin
    gnt_vld_o = |req_i;
    gnt_id_o  = 1'b0;
    case (req_i)
      2'b10:   gnt_id_o = 1'b1;
      2'b11:   gnt_id_o = ptr_i;
      default: gnt_id_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 256x16 sync RAM between two masters (IO window with MEM_ARBITER_IO_EN).
// Latency: request seen in IDLE at T -> RAM access at T+1 -> one-cycle ack with read data at T+2.
// Backpressure: masters hold their request until acked; back-to-back grants alternate via DONE->ACCESS.
module mem_arbiter
  import mem_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  logic [1:0] state_q, state_d;
  logic       ptr_q, ptr_d;
  req_t       cur_q, cur_d;
  logic       ram_write_q, ram_write_d;
  logic [1:0] req_raw, req_eff;
  logic       gnt_id, gnt_vld;
  req_t       win;
  logic       done, rd_ok;
  logic [DW-1:0] rd_val;
`ifdef MEM_ARBITER_IO_EN
  logic       io_write_q, io_write_d;
`endif

  assign req_raw = {cmd_vld(bus.m1_cmd), cmd_vld(bus.m0_cmd)};

  // Only IDLE and DONE can grant; in DONE the just-acked master is masked out
  always_comb begin
    req_eff = 2'b00;
    case (state_q)
      IDLE:    req_eff = req_raw;
      DONE:    req_eff = cur_q.id ? {1'b0, req_raw[0]} : {req_raw[1], 1'b0};
      default: req_eff = 2'b00;
    endcase
  end

  rr_arb2 u_rr (
    .req_i    (req_eff),
    .ptr_i    (ptr_q),
    .gnt_id_o (gnt_id),
    .gnt_vld_o(gnt_vld)
  );

  // Select the winning master's request fields
  always_comb begin
    win.id    = gnt_id;
    win.cmd   = gnt_id ? bus.m1_cmd   : bus.m0_cmd;
    win.addr  = gnt_id ? bus.m1_addr  : bus.m0_addr;
    win.wdata = gnt_id ? bus.m1_wdata : bus.m0_wdata;
  end

  // Next-state: a grant loads the transaction and arms the write strobe for exactly the ACCESS cycle
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cur_d       = cur_q;
    ram_write_d = 1'b0;
`ifdef MEM_ARBITER_IO_EN
    io_write_d  = 1'b0;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (gnt_vld) begin
          state_d     = ACCESS;
          ptr_d       = ~gnt_id;
          cur_d       = win;
          ram_write_d = (win.cmd == MWRITE) && !win.addr[RAM_SEL_BIT];
`ifdef MEM_ARBITER_IO_EN
          io_write_d  = (win.cmd == MWRITE) && win.addr[RAM_SEL_BIT];
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any in-flight transaction and drops the write strobe at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      cur_q       <= '0;
      ram_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cur_q       <= cur_d;
      ram_write_q <= ram_write_d;
    end
  end

`ifdef MEM_ARBITER_IO_EN
  // IO write strobe, same timing as the RAM one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) io_write_q <= 1'b0;
    else        io_write_q <= io_write_d;
  end

  assign bus.io_addr  = cur_q.addr[AW-2:0];
  assign bus.io_wdata = cur_q.wdata;
  assign bus.io_write = io_write_q;
  assign rd_val       = cur_q.addr[RAM_SEL_BIT] ? bus.io_rdata : bus.ram_dout;
`else
  // Without the IO window, reads above the RAM return zero
  assign rd_val       = cur_q.addr[RAM_SEL_BIT] ? '0 : bus.ram_dout;
`endif

  // RAM address/data come straight from the latched transaction registers
  assign bus.ram_addr  = cur_q.addr[AW-2:0];
  assign bus.ram_din   = cur_q.wdata;
  assign bus.ram_write = ram_write_q;

  assign done  = (state_q == DONE);
  assign rd_ok = done && (cur_q.cmd == MREAD);

  assign bus.m0_ack   = done && !cur_q.id;
  assign bus.m1_ack   = done &&  cur_q.id;
  assign bus.m0_rdata = (rd_ok && !cur_q.id) ? rd_val : '0;
  assign bus.m1_rdata = (rd_ok &&  cur_q.id) ? rd_val : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256x16 sync RAM.
// Latency: checks ACCESS at T+1 and ack at T+2 after a request in IDLE.
// Backpressure: masters hold requests until acked, as the arbiter expects.
module tb_mem_arbiter;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   wr_cnt   = 0;
  int   wr_base;
  logic [DW-1:0] mem [256];

  mem_arbiter_if bus ();

  mem_arbiter u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM: read-first, one-edge read latency
  always @(posedge clk) begin
    if (bus.ram_write) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  // Count write-strobe cycles
  always @(negedge clk) if (bus.ram_write === 1'b1) wr_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    reset = 1'b0;
    bus.m0_cmd = MNONE; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_cmd = MNONE; bus.m1_addr = '0; bus.m1_wdata = '0;
`ifdef MEM_ARBITER_IO_EN
    bus.io_rdata = 16'h7E57;
`endif

    // Reset held with m0 reading: nothing happens
    @(negedge clk);
    bus.m0_cmd = MREAD; bus.m0_addr = 9'h000;
    @(negedge clk);
    check("rst_m0_ack",    32'(bus.m0_ack),    32'h0);
    check("rst_m1_ack",    32'(bus.m1_ack),    32'h0);
    check("rst_ram_write", 32'(bus.ram_write), 32'h0);
    check("rst_ram_addr",  32'(bus.ram_addr),  32'h0);
    check("rst_ram_din",   32'(bus.ram_din),   32'h0);
    check("rst_m0_rdata",  32'(bus.m0_rdata),  32'h0);
    check("rst_m1_rdata",  32'(bus.m1_rdata),  32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_access_ack",   32'(bus.m0_ack),    32'h0);
    check("rel_access_write", 32'(bus.ram_write), 32'h0);
    @(negedge clk);
    check("rel_done_ack",   32'(bus.m0_ack),   32'h1);
    check("rel_done_rdata", 32'(bus.m0_rdata), 32'h1000);
    bus.m0_cmd = MNONE;
    @(negedge clk);
    check("rel_ack_pulse", 32'(bus.m0_ack), 32'h0);

    // m0 writes ABCD to 0x010, m1 reads it back through DONE->ACCESS
    wr_base = wr_cnt;
    bus.m0_cmd = MWRITE; bus.m0_addr = 9'h010; bus.m0_wdata = 16'hABCD;
    @(negedge clk);
    check("wr_ram_write", 32'(bus.ram_write), 32'h1);
    check("wr_ram_addr",  32'(bus.ram_addr),  32'h10);
    check("wr_ram_din",   32'(bus.ram_din),   32'hABCD);
    @(negedge clk);
    check("wr_m0_ack",    32'(bus.m0_ack),    32'h1);
    check("wr_m0_rdata",  32'(bus.m0_rdata),  32'h0);
    bus.m0_cmd = MNONE;
    bus.m1_cmd = MREAD; bus.m1_addr = 9'h010;
    @(negedge clk);
    check("rd_access_write", 32'(bus.ram_write), 32'h0);
    check("rd_access_ack",   32'(bus.m1_ack),    32'h0);
    @(negedge clk);
    check("rd_m1_ack",   32'(bus.m1_ack),   32'h1);
    check("rd_m1_rdata", 32'(bus.m1_rdata), 32'hABCD);
    check("rd_m0_ack",   32'(bus.m0_ack),   32'h0);
    bus.m1_cmd = MNONE;
    @(negedge clk);
    check("wr_pulse_count", 32'(wr_cnt - wr_base), 32'h1);

    // Both masters reading continuously from reset: strict alternation
    reset = 1'b0;
    bus.m0_cmd = MREAD; bus.m0_addr = 9'h005;
    bus.m1_cmd = MREAD; bus.m1_addr = 9'h006;
    @(negedge clk);
    reset = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      @(negedge clk);
      check($sformatf("rr_ack0_s%0d", s), 32'(bus.m0_ack), 32'((s == 2) || (s == 6)));
      check($sformatf("rr_ack1_s%0d", s), 32'(bus.m1_ack), 32'((s == 4) || (s == 8)));
      check($sformatf("rr_rd0_s%0d", s), 32'(bus.m0_rdata), ((s == 2) || (s == 6)) ? 32'h1005 : 32'h0);
      check($sformatf("rr_rd1_s%0d", s), 32'(bus.m1_rdata), ((s == 4) || (s == 8)) ? 32'h1006 : 32'h0);
    end
    bus.m0_cmd = MNONE; bus.m1_cmd = MNONE;
    @(negedge clk);
    check("rr_idle_ack0", 32'(bus.m0_ack), 32'h0);
    check("rr_idle_ack1", 32'(bus.m1_ack), 32'h0);

    // m1 write then read above the RAM window (0x120)
    bus.m1_cmd = MWRITE; bus.m1_addr = 9'h120; bus.m1_wdata = 16'h5555;
    @(negedge clk);
    check("hi_wr_ram_write", 32'(bus.ram_write), 32'h0);
`ifdef MEM_ARBITER_IO_EN
    check("hi_wr_io_write", 32'(bus.io_write), 32'h1);
    check("hi_wr_io_addr",  32'(bus.io_addr),  32'h20);
    check("hi_wr_io_wdata", 32'(bus.io_wdata), 32'h5555);
`endif
    @(negedge clk);
    check("hi_wr_ack", 32'(bus.m1_ack), 32'h1);
`ifdef MEM_ARBITER_IO_EN
    check("hi_wr_io_write_done", 32'(bus.io_write), 32'h0);
`endif
    bus.m1_cmd = MREAD;
    @(negedge clk);
    check("hi_rd_idle_ack", 32'(bus.m1_ack), 32'h0);
    @(negedge clk);
    check("hi_rd_ram_write", 32'(bus.ram_write), 32'h0);
    @(negedge clk);
    check("hi_rd_ack", 32'(bus.m1_ack), 32'h1);
`ifdef MEM_ARBITER_IO_EN
    check("hi_rd_rdata", 32'(bus.m1_rdata), 32'h7E57);
`else
    check("hi_rd_rdata", 32'(bus.m1_rdata), 32'h0);
`endif
    check("hi_ram_untouched", 32'(mem[8'h20]), 32'h1020);
    bus.m1_cmd = MNONE;
    @(negedge clk);

    // Reset during the ACCESS cycle of a write aborts it
    bus.m0_cmd = MWRITE; bus.m0_addr = 9'h030; bus.m0_wdata = 16'hDEAD;
    @(posedge clk);
    #1;
    check("abort_write_hi", 32'(bus.ram_write), 32'h1);
    reset = 1'b0;
    #1;
    check("abort_write_drop", 32'(bus.ram_write), 32'h0);
    @(negedge clk);
    bus.m0_cmd = MNONE;
    check("abort_ack0", 32'(bus.m0_ack), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("abort_no_ack0", 32'(bus.m0_ack), 32'h0);
    check("abort_no_ack1", 32'(bus.m1_ack), 32'h0);
    check("abort_ram_word", 32'(mem[8'h30]), 32'h1030);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master memory arbiter that shares the single-port 256x16 RAM between the `cpu` and a second master such as a program loader or DMA engine. It accepts `mem_cmd`/`mem_addr`-style requests from each master, grants one at a time with round-robin fairness, and drives the RAM address, write-enable and data lines. It returns read data with a one-cycle acknowledge. It sits between the masters and `RAM`, replacing the combinational read/write glue in the top level.

## Interface
- `AW`, 9: address width; bit `AW-1` = 0 selects RAM.
- `DW`, 16: data width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `m0_cmd`, `m1_cmd`  in  2 each  command: 00 none, 01 read, 10 write, 11 treated as none.
- `m0_addr`, `m1_addr`  in  AW each  word address.
- `m0_wdata`, `m1_wdata`  in  DW each  write data.
- `m0_ack`, `m1_ack`  out  1 each  one-cycle transaction-complete pulse.
- `m0_rdata`, `m1_rdata`  out  DW each  read data; valid only while the matching ack is high.
- `ram_addr`  out  AW-1  RAM address, registered.
- `ram_din`  out  DW  RAM write data, registered.
- `ram_write`  out  1  RAM write enable.
- `ram_dout`  in  DW  RAM synchronous read data; valid one edge after the address.

## Operation
- Masters hold `cmd`, `addr` and `wdata` stable from request until the cycle their ack is high. After that they may drop the request or present the next one.
- FSM states:
  - IDLE: if any request is pending, latch the winner's id, cmd, addr and wdata, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: drive `ram_addr` and `ram_din` from the latched values. `ram_write` = (cmd==10) and addr[AW-1]==0. Go to DONE.
  - DONE: assert the winner's ack. Winner rdata = `ram_dout` for a RAM read, 0 for a write.
- Leaving DONE:
  - If the other master is requesting, grant it and go straight to ACCESS.
  - Otherwise go to IDLE.
  - The acked master's request is ignored in DONE, because it is the transaction just finished.
- Round-robin:
  - A priority pointer selects the favoured master when both request in IDLE.
  - After every grant, the pointer moves to the other master.
  - Reset value of the pointer is m0 (CPU).
- Accesses with addr[AW-1]==1: see Configuration.
- Outputs for the non-winning master: ack 0, rdata 0.

## Timing
- Reset values: state IDLE, pointer m0, `m0_ack`/`m1_ack` 0, `ram_write` 0, `ram_addr` 0, `ram_din` 0, rdata outputs 0.
- Request first seen in IDLE at cycle T: ACCESS at T+1, ack at T+2. The master may issue a new command at T+3.
- With both masters continuously busy, they alternate. Each master gets one access every 4 cycles; the RAM is used in 2 cycles out of every 4 (ACCESS, DONE, ACCESS, DONE ...).
- Exactly one `ram_write` cycle per write transaction. `ram_write` is never high outside ACCESS.
- Reset asserted in ACCESS or DONE:
  - The transaction is aborted immediately: `ram_write` drops asynchronously and no ack is issued.
  - The master must reissue the request after reset.
- Both masters request the same address in the same cycle: they are serialised by the pointer; the second sees the first's write.

## Configuration
- Macro: `MEM_ARBITER_IO_EN`.
- Defined:
  - Adds ports `io_addr` (out, AW-1), `io_write` (out, 1), `io_wdata` (out, DW) and `io_rdata` (in, DW).
  - Accesses with addr[AW-1]==1 drive the io ports in ACCESS, with the same timing as RAM, and return `io_rdata` in DONE.
- Undefined:
  - Accesses with addr[AW-1]==1 are acked with normal timing.
  - Writes are discarded and reads return 16'h0000.
  - `ram_write` stays 0 for these accesses.

## Structure
- Shared package `mem_pkg` holds:
  - command constants MNONE=2'b00, MREAD=2'b01, MWRITE=2'b10;
  - the FSM state encoding (IDLE, ACCESS, DONE);
  - RAM_SEL_BIT = AW-1.
- Sub-module `rr_arb2`: a combinational two-way round-robin picker with the pointer kept in the parent. It takes two request bits and the pointer, and returns the grant id and grant-valid.

## Test plan
- Reset with `m0_cmd`=01 held → no ack, `ram_write`=0. After reset release, `m0_ack` pulses 2 cycles after the first IDLE sample.
- m0 writes 16'hABCD to address 9'h010, then m1 reads 9'h010 → `m1_rdata`=16'hABCD while `m1_ack`=1. Exactly one `ram_write` pulse is seen.
- Both masters read continuously from reset → ack order m0, m1, m0, m1. Acks are 2 cycles apart; no master is starved.
- m1 write to 9'h120 with `MEM_ARBITER_IO_EN` undefined → ack at T+2, `ram_write` stays 0. A following read of 9'h120 returns 0.
- Same write with `MEM_ARBITER_IO_EN` defined → `io_write`=1 in ACCESS with `io_addr`=8'h20. A read returns the driven `io_rdata`.
- Reset asserted during the ACCESS cycle of a write → `ram_write` falls immediately, no ack is issued, and the RAM word is unchanged.
